// File: rtl/nios_jtag_sysclk_cmd_queue.sv
// System-clock side of the Nios II JTAG debug path: synchronises the TCK-domain
// update strobes, queues every completed DR scan and decodes the head command.
module nios_jtag_sysclk_cmd_queue #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACT_BIT     = 34,
    localparam int NUM_IR     = 2 ** IR_WIDTH,
    localparam int PW         = $clog2(FIFO_DEPTH),
    localparam int CW         = PW + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [IR_WIDTH-1:0] ir_in,
    input  logic [SR_WIDTH-1:0] sr,
    input  logic                vs_uir,
    input  logic                vs_udr,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [SR_WIDTH-1:0] jdo,
    output logic [IR_WIDTH-1:0] cmd_ir,
    output logic [NUM_IR-1:0]   take_action,
    output logic [NUM_IR-1:0]   take_no_action,
    output logic [CW-1:0]       cmd_count,
    output logic                overflow,
    input  logic                overflow_clr
);

    logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q;
    logic                   uir_edge_q, udr_edge_q;
    logic                   uir_rise, udr_rise;
    logic [IR_WIDTH-1:0]    ir_reg_q;

    logic [SR_WIDTH-1:0]    sr_mem_q [FIFO_DEPTH];
    logic [IR_WIDTH-1:0]    ir_mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   full, push, pop, drop;

    assign uir_rise = uir_sync_q[SYNC_STAGES-1] & ~uir_edge_q;
    assign udr_rise = udr_sync_q[SYNC_STAGES-1] & ~udr_edge_q;

    assign full = (count_q == CW'(FIFO_DEPTH));
    assign pop  = cmd_valid & cmd_ready;
    // A pop frees the head slot this cycle, so a push into a full FIFO is fine then.
    assign push = udr_rise & (~full | pop);
    assign drop = udr_rise & full & ~pop;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
        overflow_d = overflow_q;
        if (drop)
            overflow_d = 1'b1;
        else if (overflow_clr)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync_q <= '0;
            udr_sync_q <= '0;
            uir_edge_q <= 1'b0;
            udr_edge_q <= 1'b0;
            ir_reg_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            uir_edge_q <= uir_sync_q[SYNC_STAGES-1];
            udr_edge_q <= udr_sync_q[SYNC_STAGES-1];
            if (uir_rise)
                ir_reg_q <= ir_in;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is cleared on reset so jdo/cmd_ir read back as zero afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                sr_mem_q[i] <= '0;
                ir_mem_q[i] <= '0;
            end
        end else if (push) begin
            sr_mem_q[wr_ptr_q] <= sr;
            ir_mem_q[wr_ptr_q] <= ir_reg_q;
        end
    end

    assign cmd_valid = (count_q != '0);
    assign cmd_count = count_q;
    assign overflow  = overflow_q;
    assign jdo       = sr_mem_q[rd_ptr_q];
    assign cmd_ir    = ir_mem_q[rd_ptr_q];

    assign take_action    = (pop &  jdo[ACT_BIT]) ? (NUM_IR'(1) << cmd_ir) : '0;
    assign take_no_action = (pop & ~jdo[ACT_BIT]) ? (NUM_IR'(1) << cmd_ir) : '0;

endmodule

// File: tb/tb_nios_jtag_sysclk_cmd_queue.sv
// Directed bench for nios_jtag_sysclk_cmd_queue: scans, FIFO fill/drain,
// overflow, simultaneous push/pop, strobe collisions and asynchronous reset.
module tb_nios_jtag_sysclk_cmd_queue;

    localparam int SR_WIDTH = 38;
    localparam int IR_WIDTH = 2;
    localparam int SYNC     = 2;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [IR_WIDTH-1:0] ir_in = '0;
    logic [SR_WIDTH-1:0] sr = '0;
    logic                vs_uir = 1'b0;
    logic                vs_udr = 1'b0;
    logic                cmd_valid;
    logic                cmd_ready = 1'b0;
    logic [SR_WIDTH-1:0] jdo;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [3:0]          take_action;
    logic [3:0]          take_no_action;
    logic [2:0]          cmd_count;
    logic                overflow;
    logic                overflow_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    nios_jtag_sysclk_cmd_queue dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ir_in          (ir_in),
        .sr             (sr),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .jdo            (jdo),
        .cmd_ir         (cmd_ir),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .cmd_count      (cmd_count),
        .overflow       (overflow),
        .overflow_clr   (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_uir(input logic [IR_WIDTH-1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        repeat (3) tick();
        vs_uir = 1'b0;
        repeat (4) tick();
    endtask

    task automatic do_udr(input logic [SR_WIDTH-1:0] data);
        sr     = data;
        vs_udr = 1'b1;
        repeat (3) tick();
        vs_udr = 1'b0;
        repeat (4) tick();
    endtask

    // Scan with the consumer ready; the command must pop in its first valid cycle.
    task automatic scan_and_check(input logic [IR_WIDTH-1:0] ir, input logic [SR_WIDTH-1:0] data,
                                  input logic [3:0] exp_act, input logic [3:0] exp_nact);
        int n;
        do_uir(ir);
        cmd_ready = 1'b1;
        sr        = data;
        vs_udr    = 1'b1;
        n         = 0;
        while (!cmd_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("latency", 64'(n), 64'(SYNC + 1));
        check_eq("jdo", 64'(jdo), 64'(data));
        check_eq("cmd_ir", 64'(cmd_ir), 64'(ir));
        check_eq("take_action", 64'(take_action), 64'(exp_act));
        check_eq("take_no_action", 64'(take_no_action), 64'(exp_nact));
        vs_udr = 1'b0;
        tick();
        check_eq("valid_after_pop", 64'(cmd_valid), 64'd0);
        check_eq("pulse_one_cycle", 64'({take_action, take_no_action}), 64'd0);
        repeat (4) tick();
        check_eq("count_after_scan", 64'(cmd_count), 64'd0);
        cmd_ready = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        check_eq("rst_count", 64'(cmd_count), 64'd0);
        check_eq("rst_valid", 64'(cmd_valid), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);
        check_eq("rst_jdo", 64'(jdo), 64'd0);
        check_eq("rst_cmd_ir", 64'(cmd_ir), 64'd0);
        check_eq("rst_pulses", 64'({take_action, take_no_action}), 64'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        scan_and_check(2'b01, 38'h04_0000_1234, 4'b0010, 4'b0000);
        scan_and_check(2'b11, 38'h00_0000_00ab, 4'b0000, 4'b1000);

        // Five scans into a four-deep queue with nobody consuming.
        for (int v = 1; v <= 5; v++) do_udr(SR_WIDTH'(v));
        check_eq("fill_count", 64'(cmd_count), 64'd4);
        check_eq("fill_overflow", 64'(overflow), 64'd1);
        cmd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_eq("drain_jdo", 64'(jdo), 64'(i));
            check_eq("drain_count", 64'(cmd_count), 64'(5 - i));
            tick();
        end
        cmd_ready = 1'b0;
        check_eq("drained_count", 64'(cmd_count), 64'd0);
        check_eq("overflow_sticky", 64'(overflow), 64'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check_eq("overflow_clr", 64'(overflow), 64'd0);

        // Push into a full queue in the same cycle as a pop.
        for (int v = 11; v <= 14; v++) do_udr(SR_WIDTH'(v));
        check_eq("full_count", 64'(cmd_count), 64'd4);
        sr     = 38'd15;
        vs_udr = 1'b1;
        repeat (SYNC) tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check_eq("pushpop_count", 64'(cmd_count), 64'd4);
        check_eq("pushpop_overflow", 64'(overflow), 64'd0);
        vs_udr = 1'b0;
        repeat (4) tick();
        cmd_ready = 1'b1;
        for (int i = 12; i <= 15; i++) begin
            check_eq("pushpop_jdo", 64'(jdo), 64'(i));
            tick();
        end
        cmd_ready = 1'b0;
        check_eq("pushpop_empty", 64'(cmd_count), 64'd0);

        // A long strobe is a single scan.
        sr     = 38'h2a;
        vs_udr = 1'b1;
        repeat (20) tick();
        vs_udr = 1'b0;
        repeat (4) tick();
        check_eq("held_udr_count", 64'(cmd_count), 64'd1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;

        // Simultaneous IR and DR updates: the DR scan keeps the previous IR.
        do_uir(2'b00);
        ir_in  = 2'b10;
        sr     = 38'h77;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        repeat (3) tick();
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        repeat (4) tick();
        check_eq("collide_count", 64'(cmd_count), 64'd1);
        check_eq("collide_ir", 64'(cmd_ir), 64'd0);
        do_udr(38'h78);
        check_eq("next_count", 64'(cmd_count), 64'd2);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check_eq("next_ir", 64'(cmd_ir), 64'd2);
        check_eq("next_jdo", 64'(jdo), 64'h78);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;

        // Asynchronous reset in the middle of a clock low phase.
        for (int v = 21; v <= 23; v++) do_udr(SR_WIDTH'(v));
        check_eq("pre_reset_count", 64'(cmd_count), 64'd3);
        #1 reset_n = 1'b0;
        #1;
        check_eq("async_reset_count", 64'(cmd_count), 64'd0);
        check_eq("async_reset_valid", 64'(cmd_valid), 64'd0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
